// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin selection among functional-unit result
// ports into a single registered CDB slot. The slot can drain and refill in the
// same cycle, giving one result per cycle while the consumer is ready.

package cdb_pkg;
    typedef struct packed {
        logic [4:0]  rob_idx;
        logic [31:0] res_value;
        logic        except_raised;
        logic [3:0]  except_code;
    } cdb_data_t;
endpackage

module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter  int NUM_FU   = 4,
    localparam int FU_IDX_W = $clog2(NUM_FU)
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   flush_i,
    input  logic [NUM_FU-1:0]      fu_valid_i,
    output logic [NUM_FU-1:0]      fu_ready_o,
    input  cdb_data_t [NUM_FU-1:0] fu_data_i,
    output logic                   cdb_valid_o,
    input  logic                   cdb_ready_i,
    output cdb_data_t              cdb_data_o,
    output logic [FU_IDX_W-1:0]    cdb_fu_idx_o
);

    logic                cdb_valid_q, cdb_valid_d;
    cdb_data_t           cdb_data_q, cdb_data_d;
    logic [FU_IDX_W-1:0] cdb_fu_idx_q, cdb_fu_idx_d;
    logic [FU_IDX_W-1:0] rr_ptr_q, rr_ptr_d;

    logic [NUM_FU-1:0]   grant;
    logic                grant_found;
    logic [FU_IDX_W-1:0] grant_idx;
    logic                slot_free;
    logic                accept;

    // Round-robin search: first valid requester starting at rr_ptr, wrapping.
    always_comb begin
        int                  cand;
        logic [FU_IDX_W-1:0] idx;
        cand        = 0;
        idx         = '0;
        grant       = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= NUM_FU) cand = cand - NUM_FU;
            idx = FU_IDX_W'(cand);
            if (!grant_found && fu_valid_i[idx]) begin
                grant_found = 1'b1;
                grant_idx   = idx;
                grant[idx]  = 1'b1;
            end
        end
    end

    // The slot accepts when empty or being drained this cycle; flush blocks all accepts.
    assign slot_free  = !cdb_valid_q || cdb_ready_i;
    assign fu_ready_o = grant & {NUM_FU{slot_free && !flush_i}};
    assign accept     = grant_found && slot_free && !flush_i;

    // Next-state for the CDB slot and the round-robin pointer; flush wins over all.
    always_comb begin
        cdb_valid_d  = cdb_valid_q;
        cdb_data_d   = cdb_data_q;
        cdb_fu_idx_d = cdb_fu_idx_q;
        rr_ptr_d     = rr_ptr_q;
        if (flush_i) begin
            cdb_valid_d = 1'b0;
            rr_ptr_d    = '0;
        end else if (accept) begin
            cdb_valid_d  = 1'b1;
            cdb_data_d   = fu_data_i[grant_idx];
            cdb_fu_idx_d = grant_idx;
            rr_ptr_d     = (grant_idx == FU_IDX_W'(NUM_FU - 1)) ? '0
                                                                : grant_idx + FU_IDX_W'(1);
        end else if (cdb_ready_i) begin
            // Drained with nothing to refill; payload is left as-is.
            cdb_valid_d = 1'b0;
        end
    end

    // Slot and pointer registers; reset empties the slot immediately.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cdb_valid_q  <= 1'b0;
            cdb_data_q   <= '0;
            cdb_fu_idx_q <= '0;
            rr_ptr_q     <= '0;
        end else begin
            cdb_valid_q  <= cdb_valid_d;
            cdb_data_q   <= cdb_data_d;
            cdb_fu_idx_q <= cdb_fu_idx_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    assign cdb_valid_o  = cdb_valid_q;
    assign cdb_data_o   = cdb_data_q;
    assign cdb_fu_idx_o = cdb_fu_idx_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed and randomized checks for the CDB arbiter.

module tb_cdb_arbiter;
    import cdb_pkg::*;

    localparam int NUM_FU   = 4;
    localparam int FU_IDX_W = 2;

    logic                   clk_i = 1'b0;
    logic                   rst_n_i;
    logic                   flush_i;
    logic [NUM_FU-1:0]      fu_valid_i;
    logic [NUM_FU-1:0]      fu_ready_o;
    cdb_data_t [NUM_FU-1:0] fu_data_i;
    logic                   cdb_valid_o;
    logic                   cdb_ready_i;
    cdb_data_t              cdb_data_o;
    logic [FU_IDX_W-1:0]    cdb_fu_idx_o;

    int tests = 0;
    int fails = 0;

    cdb_arbiter #(.NUM_FU(NUM_FU)) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .flush_i      (flush_i),
        .fu_valid_i   (fu_valid_i),
        .fu_ready_o   (fu_ready_o),
        .fu_data_i    (fu_data_i),
        .cdb_valid_o  (cdb_valid_o),
        .cdb_ready_i  (cdb_ready_i),
        .cdb_data_o   (cdb_data_o),
        .cdb_fu_idx_o (cdb_fu_idx_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic cdb_data_t mk(input int fu, input int tag);
        cdb_data_t d;
        d.rob_idx       = tag[4:0];
        d.res_value     = 32'hA000_0000 | (fu << 16) | tag;
        d.except_raised = tag[0];
        d.except_code   = fu[3:0];
        return d;
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_flush();
        flush_i    = 1'b1;
        fu_valid_i = '0;
        step();
        flush_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n_i     = 1'b0;
        flush_i     = 1'b0;
        fu_valid_i  = '0;
        cdb_ready_i = 1'b1;
        for (int i = 0; i < NUM_FU; i++) fu_data_i[i] = mk(i, i);
        #3;
        tests++;
        if (cdb_valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", cdb_valid_o); end
        tests++;
        if (cdb_data_o !== cdb_data_t'('0)) begin fails++; $display("FAIL reset_data: got %h want 0", cdb_data_o); end
        tests++;
        if (cdb_fu_idx_o !== 2'd0) begin fails++; $display("FAIL reset_idx: got %0d want 0", cdb_fu_idx_o); end
        tests++;
        if (dut.rr_ptr_q !== 2'd0) begin fails++; $display("FAIL reset_rr: got %0d want 0", dut.rr_ptr_q); end
        fu_valid_i = 4'b0100;
        #1;
        tests++;
        if (fu_ready_o !== 4'b0100) begin fails++; $display("FAIL reset_ready_comb: got %b want 0100", fu_ready_o); end
        fu_valid_i = '0;
        step();
        rst_n_i = 1'b1;
        step();
    endtask

    task automatic test_single();
        fu_valid_i   = 4'b0001;
        cdb_ready_i  = 1'b1;
        fu_data_i[0] = mk(0, 5);
        #1;
        tests++;
        if (fu_ready_o !== 4'b0001) begin fails++; $display("FAIL single_ready: got %b want 0001", fu_ready_o); end
        step();
        fu_valid_i = '0;
        tests++;
        if (cdb_valid_o !== 1'b1 || cdb_fu_idx_o !== 2'd0 || cdb_data_o !== mk(0, 5)) begin
            fails++; $display("FAIL single_out: got v=%b idx=%0d d=%h want v=1 idx=0 d=%h", cdb_valid_o, cdb_fu_idx_o, cdb_data_o, mk(0, 5));
        end
        tests++;
        if (dut.rr_ptr_q !== 2'd1) begin fails++; $display("FAIL single_rr: got %0d want 1", dut.rr_ptr_q); end
        step();
        tests++;
        if (cdb_valid_o !== 1'b0) begin fails++; $display("FAIL single_drain: got %b want 0", cdb_valid_o); end
    endtask

    task automatic test_round_robin();
        int exp;
        do_flush();
        for (int i = 0; i < NUM_FU; i++) fu_data_i[i] = mk(i, i + 8);
        fu_valid_i  = 4'b1111;
        cdb_ready_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            exp = k % NUM_FU;
            #1;
            tests++;
            if (fu_ready_o !== (4'b0001 << exp)) begin fails++; $display("FAIL rr_ready[%0d]: got %b want fu %0d", k, fu_ready_o, exp); end
            step();
            tests++;
            if (cdb_valid_o !== 1'b1 || cdb_fu_idx_o !== exp[1:0] || cdb_data_o !== mk(exp, exp + 8)) begin
                fails++; $display("FAIL rr_out[%0d]: got v=%b idx=%0d d=%h want idx=%0d", k, cdb_valid_o, cdb_fu_idx_o, cdb_data_o, exp);
            end
        end
        fu_valid_i = '0;
        step();
    endtask

    task automatic test_backpressure();
        do_flush();
        cdb_ready_i  = 1'b1;
        fu_valid_i   = 4'b0100;
        fu_data_i[2] = mk(2, 3);
        step();
        fu_valid_i   = 4'b1000;
        fu_data_i[2] = mk(2, 17);
        fu_data_i[3] = mk(3, 7);
        cdb_ready_i  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            tests++;
            if (fu_ready_o !== 4'b0000) begin fails++; $display("FAIL bp_ready[%0d]: got %b want 0000", k, fu_ready_o); end
            tests++;
            if (cdb_valid_o !== 1'b1 || cdb_fu_idx_o !== 2'd2 || cdb_data_o !== mk(2, 3) || dut.rr_ptr_q !== 2'd3) begin
                fails++; $display("FAIL bp_hold[%0d]: got v=%b idx=%0d d=%h rr=%0d want v=1 idx=2 rr=3", k, cdb_valid_o, cdb_fu_idx_o, cdb_data_o, dut.rr_ptr_q);
            end
            step();
        end
        cdb_ready_i = 1'b1;
        #1;
        tests++;
        if (fu_ready_o !== 4'b1000) begin fails++; $display("FAIL bp_release_ready: got %b want 1000", fu_ready_o); end
        step();
        fu_valid_i = '0;
        tests++;
        if (cdb_valid_o !== 1'b1 || cdb_fu_idx_o !== 2'd3 || cdb_data_o !== mk(3, 7) || dut.rr_ptr_q !== 2'd0) begin
            fails++; $display("FAIL bp_release_out: got v=%b idx=%0d d=%h rr=%0d want idx=3 rr=0", cdb_valid_o, cdb_fu_idx_o, cdb_data_o, dut.rr_ptr_q);
        end
        step();
    endtask

    task automatic test_wrap();
        do_flush();
        cdb_ready_i = 1'b1;
        fu_valid_i  = 4'b0100;
        step();
        fu_valid_i   = 4'b1001;
        fu_data_i[0] = mk(0, 21);
        fu_data_i[3] = mk(3, 22);
        #1;
        tests++;
        if (fu_ready_o !== 4'b1000) begin fails++; $display("FAIL wrap_ready3: got %b want 1000", fu_ready_o); end
        step();
        tests++;
        if (cdb_fu_idx_o !== 2'd3 || dut.rr_ptr_q !== 2'd0) begin fails++; $display("FAIL wrap_out3: got idx=%0d rr=%0d want idx=3 rr=0", cdb_fu_idx_o, dut.rr_ptr_q); end
        #1;
        tests++;
        if (fu_ready_o !== 4'b0001) begin fails++; $display("FAIL wrap_ready0: got %b want 0001", fu_ready_o); end
        step();
        fu_valid_i = '0;
        tests++;
        if (cdb_fu_idx_o !== 2'd0 || cdb_data_o !== mk(0, 21) || dut.rr_ptr_q !== 2'd1) begin
            fails++; $display("FAIL wrap_out0: got idx=%0d d=%h rr=%0d want idx=0 rr=1", cdb_fu_idx_o, cdb_data_o, dut.rr_ptr_q);
        end
        step();
    endtask

    task automatic test_flush();
        do_flush();
        cdb_ready_i = 1'b1;
        fu_valid_i  = 4'b0001;
        step();
        fu_valid_i = 4'b0010;
        flush_i    = 1'b1;
        #1;
        tests++;
        if (fu_ready_o !== 4'b0000) begin fails++; $display("FAIL flush_ready: got %b want 0000", fu_ready_o); end
        step();
        flush_i    = 1'b0;
        fu_valid_i = '0;
        tests++;
        if (cdb_valid_o !== 1'b0 || dut.rr_ptr_q !== 2'd0) begin fails++; $display("FAIL flush_out: got v=%b rr=%0d want v=0 rr=0", cdb_valid_o, dut.rr_ptr_q); end
    endtask

    task automatic test_async_reset();
        cdb_ready_i = 1'b0;
        fu_valid_i  = 4'b0010;
        step();
        fu_valid_i = '0;
        #2;
        rst_n_i = 1'b0;
        #1;
        tests++;
        if (cdb_valid_o !== 1'b0 || cdb_data_o !== cdb_data_t'('0)) begin
            fails++; $display("FAIL async_reset: got v=%b d=%h want v=0 d=0", cdb_valid_o, cdb_data_o);
        end
        step();
        rst_n_i     = 1'b1;
        cdb_ready_i = 1'b1;
        step();
    endtask

    task automatic test_random();
        logic [NUM_FU-1:0] vld;
        cdb_data_t         pend [NUM_FU];
        int                wait_cnt [NUM_FU];
        logic              m_valid;
        cdb_data_t         m_data;
        int                m_idx;
        int                m_rr;
        int                seq;
        int                g;
        logic [NUM_FU-1:0] exp_ready;
        logic              rdy;
        do_flush();
        vld     = '0;
        m_valid = 1'b0;
        m_data  = '0;
        m_idx   = 0;
        m_rr    = 0;
        seq     = 100;
        for (int i = 0; i < NUM_FU; i++) begin wait_cnt[i] = 0; pend[i] = '0; end
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (!vld[i] && ($urandom_range(0, 1) == 1)) begin
                    vld[i]  = 1'b1;
                    pend[i] = mk(i, seq);
                    seq++;
                end
                fu_data_i[i] = pend[i];
            end
            rdy         = ($urandom_range(0, 3) != 0);
            fu_valid_i  = vld;
            cdb_ready_i = rdy;
            g = -1;
            for (int k = 0; k < NUM_FU; k++) begin
                if (g < 0 && vld[(m_rr + k) % NUM_FU]) g = (m_rr + k) % NUM_FU;
            end
            exp_ready = '0;
            if (g >= 0 && (!m_valid || rdy)) exp_ready[g] = 1'b1;
            #1;
            tests++;
            if (fu_ready_o !== exp_ready) begin fails++; $display("FAIL rand_ready@%0d: got %b want %b", c, fu_ready_o, exp_ready); end
            tests++;
            if (cdb_valid_o !== m_valid || (m_valid && (cdb_data_o !== m_data || int'(cdb_fu_idx_o) != m_idx))) begin
                fails++; $display("FAIL rand_slot@%0d: got v=%b idx=%0d d=%h want v=%b idx=%0d d=%h", c, cdb_valid_o, cdb_fu_idx_o, cdb_data_o, m_valid, m_idx, m_data);
            end
            if (exp_ready != '0) begin
                tests++;
                if (wait_cnt[g] > NUM_FU - 1) begin fails++; $display("FAIL rand_starve@%0d: fu %0d waited %0d grants, limit %0d", c, g, wait_cnt[g], NUM_FU - 1); end
                for (int i = 0; i < NUM_FU; i++) if (i != g && vld[i]) wait_cnt[i]++;
                wait_cnt[g] = 0;
                m_valid = 1'b1;
                m_data  = pend[g];
                m_idx   = g;
                m_rr    = (g + 1) % NUM_FU;
                vld[g]  = 1'b0;
            end else if (rdy) begin
                m_valid = 1'b0;
            end
            step();
        end
        fu_valid_i  = '0;
        cdb_ready_i = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_wrap();
        test_flush();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
